// File: rtl/tmds_pkg.sv
// Shared types and constants for the TMDS DC-balance stage.
package tmds_pkg;

  localparam int CNT_W_DEFAULT = 6;

  typedef logic [9:0] tmds_sym_t;

  localparam tmds_sym_t CTRL_TOK_00 = 10'b1101010100;
  localparam tmds_sym_t CTRL_TOK_01 = 10'b0010101011;
  localparam tmds_sym_t CTRL_TOK_10 = 10'b0101010100;
  localparam tmds_sym_t CTRL_TOK_11 = 10'b1010101011;

  function automatic tmds_sym_t ctrl_token(input logic [1:0] c);
    tmds_sym_t tok;
    case (c)
      2'b00:   tok = CTRL_TOK_00;
      2'b01:   tok = CTRL_TOK_01;
      2'b10:   tok = CTRL_TOK_10;
      default: tok = CTRL_TOK_11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/ones_count.sv
// Combinational popcount of an 8-bit q_m data byte.
module ones_count (
  input  logic [7:0] i_data,
  output logic [3:0] o_ones
);

  logic [3:0] w_partial [0:8];

  assign w_partial[0] = 4'd0;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_acc
      assign w_partial[gi+1] = w_partial[gi] + {3'b000, i_data[gi]};
    end
  endgenerate

  assign o_ones = w_partial[8];

endmodule

// File: rtl/tmds_stage_two.sv
// TMDS DC-balance stage: 9-bit q_m in, registered 10-bit symbol out,
// with a running-disparity counter that persists across data symbols.
module tmds_stage_two
  import tmds_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  input  logic [8:0]       st2_in,
  input  logic             data_enable,
  input  logic [1:0]       ctrl,
  output logic [9:0]       st2_out,
  output logic             out_valid,
  output logic [CNT_W-1:0] disparity
);

  localparam logic signed [CNT_W-1:0] ZERO  = '0;
  localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);

  tmds_sym_t               r_sym;
  logic                    r_valid;
  logic signed [CNT_W-1:0] r_cnt;

  tmds_sym_t               w_sym;
  logic signed [CNT_W-1:0] w_cnt_next;
  logic signed [CNT_W-1:0] w_n1_ext;
  logic signed [CNT_W-1:0] w_diff;
  logic [3:0]              w_n1;
  logic [7:0]              w_d;
  logic                    w_xor;
  logic                    w_cnt_zero;
  logic                    w_cnt_neg;
  logic                    w_cnt_pos;

  ones_count u_ones_count (
    .i_data (st2_in[7:0]),
    .o_ones (w_n1)
  );

  assign w_d        = st2_in[7:0];
  assign w_xor      = st2_in[8];
  assign w_n1_ext   = CNT_W'(w_n1);
  // N1 - N0 == 2*N1 - 8
  assign w_diff     = w_n1_ext + w_n1_ext - EIGHT;
  assign w_cnt_zero = (r_cnt == ZERO);
  assign w_cnt_neg  = r_cnt[CNT_W-1];
  assign w_cnt_pos  = !w_cnt_neg && !w_cnt_zero;

  always_comb begin
    w_sym      = r_sym;
    w_cnt_next = r_cnt;
    if (w_cnt_zero || (w_n1 == 4'd4)) begin
      w_sym      = {~w_xor, w_xor, (w_xor ? w_d : ~w_d)};
      w_cnt_next = w_xor ? (r_cnt + w_diff) : (r_cnt - w_diff);
    end else if ((w_cnt_pos && (w_n1 > 4'd4)) || (w_cnt_neg && (w_n1 < 4'd4))) begin
      w_sym      = {1'b1, w_xor, ~w_d};
      w_cnt_next = r_cnt + (w_xor ? TWO : ZERO) - w_diff;
    end else begin
      w_sym      = {1'b0, w_xor, w_d};
      w_cnt_next = r_cnt + w_diff - (w_xor ? ZERO : TWO);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sym   <= CTRL_TOK_00;
      r_valid <= 1'b0;
      r_cnt   <= ZERO;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        if (data_enable) begin
          r_sym <= w_sym;
          r_cnt <= w_cnt_next;
        end else begin
          // Blanking restarts DC balance from a neutral line.
          r_sym <= ctrl_token(ctrl);
          r_cnt <= ZERO;
        end
      end
    end
  end

  assign st2_out   = r_sym;
  assign out_valid = r_valid;
  assign disparity = r_cnt;

endmodule

// File: tb/tb_tmds_stage_two.sv
// Directed and random checks of tmds_stage_two against a scoreboard.
module tb_tmds_stage_two;

  typedef struct {
    logic [9:0] sym;
    logic [5:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [8:0] st2_in = '0;
  logic       data_enable = 1'b0;
  logic [1:0] ctrl = 2'b00;
  logic [9:0] st2_out;
  logic       out_valid;
  logic [5:0] disparity;

  int         n_assert = 0;
  int         n_fail = 0;
  int         mcnt = 0;
  logic [9:0] last_sym = 10'b1101010100;
  logic [5:0] last_cnt = '0;
  exp_t       sb[$];

  tmds_stage_two #(.CNT_W(6)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .in_valid    (in_valid),
    .st2_in      (st2_in),
    .data_enable (data_enable),
    .ctrl        (ctrl),
    .st2_out     (st2_out),
    .out_valid   (out_valid),
    .disparity   (disparity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic de, input logic [1:0] c,
                      input logic [8:0] q, input logic [9:0] es, input logic [5:0] ec,
                      input string tag);
    exp_t e;
    in_valid = v; data_enable = de; ctrl = c; st2_in = q;
    if (v) sb.push_back('{sym: es, cnt: ec});
    @(posedge clk); #1;
    chk({tag, " valid"}, {31'b0, out_valid}, {31'b0, v});
    if (v) begin
      e = sb.pop_front();
      last_sym = e.sym;
      last_cnt = e.cnt;
    end
    chk({tag, " sym"}, {22'b0, st2_out}, {22'b0, last_sym});
    chk({tag, " cnt"}, {26'b0, disparity}, {26'b0, last_cnt});
    $display("%-12s v=%0b de=%0b ctrl=%0d q=%09b -> out=%010b cnt=%0d",
             tag, v, de, c, q, st2_out, $signed(disparity));
  endtask

  task automatic dstep(input logic [8:0] q, input logic [9:0] es, input int ec, input string tag);
    mcnt = ec;
    step(1'b1, 1'b1, 2'b00, q, es, 6'(ec), tag);
  endtask

  task automatic cstep(input logic [1:0] c, input logic [9:0] es, input string tag);
    mcnt = 0;
    step(1'b1, 1'b0, c, 9'h0, es, 6'd0, tag);
  endtask

  // Reference DC-balance rule on plain integers.
  task automatic model(input logic [8:0] q, output logic [9:0] s);
    int n1, n0;
    n1 = $countones(q[7:0]);
    n0 = 8 - n1;
    if (mcnt == 0 || n1 == n0) begin
      s = {~q[8], q[8], (q[8] ? q[7:0] : ~q[7:0])};
      mcnt += q[8] ? (n1 - n0) : (n0 - n1);
    end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
      s = {1'b1, q[8], ~q[7:0]};
      mcnt += 2 * int'(q[8]) + n0 - n1;
    end else begin
      s = {1'b0, q[8], q[7:0]};
      mcnt += n1 - n0 - 2 * int'(!q[8]);
    end
  endtask

  // Transition-minimising first stage, to feed only legal q_m words.
  function automatic logic [8:0] stage_one(input logic [7:0] d);
    logic [8:0] q;
    int n;
    n = $countones(d);
    q[0] = d[0];
    if (n > 4 || (n == 4 && !d[0])) begin
      for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
      q[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
      q[8] = 1'b1;
    end
    return q;
  endfunction

  initial begin
    logic [9:0] es;
    logic [8:0] q;
    logic [1:0] c;
    logic [9:0] tok_tab [0:3];
    int r, d;
    tok_tab[0] = 10'b1101010100;
    tok_tab[1] = 10'b0010101011;
    tok_tab[2] = 10'b0101010100;
    tok_tab[3] = 10'b1010101011;

    repeat (2) @(posedge clk);
    #1;
    chk("rst sym", {22'b0, st2_out}, {22'b0, 10'b1101010100});
    chk("rst valid", {31'b0, out_valid}, 32'd0);
    chk("rst cnt", {26'b0, disparity}, 32'd0);
    n_rst = 1'b1;
    step(1'b0, 1'b1, 2'b00, 9'h0, 10'h0, 6'd0, "idle");
    step(1'b0, 1'b0, 2'b00, 9'h1ff, 10'h0, 6'd0, "idle2");

    dstep(9'b001111001, 10'b1010000110, -2, "chain0");
    dstep(9'b100000000, 10'b1111111111, 8, "chain1");
    dstep(9'b100001111, 10'b0100001111, 8, "chain2");

    for (int i = 0; i < 4; i++) cstep(2'(i), tok_tab[i], "ctrl");
    dstep(9'b001111001, 10'b1010000110, -2, "de_rise");

    dstep(9'b100000000, 10'b1111111111, 8, "pre_stall");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b00, 9'(i * 37), 10'h0, 6'd0, "stall");
    dstep(9'b100001111, 10'b0100001111, 8, "resume");

    n_rst = 1'b0;
    #1;
    chk("midrst sym", {22'b0, st2_out}, {22'b0, 10'b1101010100});
    chk("midrst valid", {31'b0, out_valid}, 32'd0);
    chk("midrst cnt", {26'b0, disparity}, 32'd0);
    $display("midrst       -> out=%010b cnt=%0d valid=%0b", st2_out, $signed(disparity), out_valid);
    n_rst = 1'b1;
    last_sym = 10'b1101010100;
    last_cnt = '0;
    mcnt = 0;
    dstep(9'b001111001, 10'b1010000110, -2, "post_rst");

    for (int i = 0; i < 10000; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        c = 2'($urandom_range(0, 3));
        cstep(c, tok_tab[c], "rnd_ctrl");
      end else if (r == 1) begin
        step(1'b0, 1'b1, 2'b00, 9'($urandom), 10'h0, 6'd0, "rnd_stall");
      end else begin
        q = stage_one(8'($urandom));
        model(q, es);
        step(1'b1, 1'b1, 2'b00, q, es, 6'(mcnt), "rnd_data");
        d = int'($signed(disparity));
        n_assert++;
        assert (d <= 10 && d >= -10)
        else begin
          n_fail++;
          $error("FAIL cnt_range: observed %0d required within +/-10", d);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
